// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// It sits beside the single-cycle ALU in EX. BUSY stalls the pipeline while
// the divider runs. RESULT is registered and is qualified by a one-cycle
// VALID pulse. Divide-by-zero and signed overflow take a fast path that
// skips the iteration phase.

module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic [XLEN-1:0] RESULT,
  output logic            VALID,
  output logic            BUSY
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // FSM encoding
  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_CALC   = 2'b01;
  localparam logic [1:0] S_FINISH = 2'b10;

  logic [1:0]      state;
  logic            op_rem;      // 1: the result is the remainder
  logic            quo_neg;     // negate the quotient at completion
  logic            rem_neg;     // negate the remainder at completion
  logic [XLEN-1:0] divisor;     // |DATA2| (signed ops) or DATA2
  logic [XLEN-1:0] rem_q;       // partial remainder
  logic [XLEN-1:0] quo_q;       // dividend bits shifting out, quotient bits shifting in
  logic [CW-1:0]   count;

  // Request decode
  logic            op_valid;
  logic            op_signed;
  logic            op_is_rem;
  logic            dividend_neg;
  logic            divisor_neg;
  logic [XLEN-1:0] dividend_abs;
  logic [XLEN-1:0] divisor_abs;
  logic            div_by_zero;
  logic            overflow;

  // Iteration datapath
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] quo_final;
  logic [XLEN-1:0] rem_final;

  // Decode the op and condition the operands for the magnitude divider
  always_comb begin
    op_valid     = (SELECT[4:2] == 3'b011);
    op_signed    = ~SELECT[0];
    op_is_rem    = SELECT[1];
    dividend_neg = op_signed & DATA1[XLEN-1];
    divisor_neg  = op_signed & DATA2[XLEN-1];
    dividend_abs = dividend_neg ? -DATA1 : DATA1;
    divisor_abs  = divisor_neg  ? -DATA2 : DATA2;
    div_by_zero  = (DATA2 == '0);
    overflow     = op_signed && (DATA1 == MOST_NEG) && (DATA2 == '1);
  end

  // One restoring step: shift {rem, quo} left, trial-subtract, keep if non-negative
  always_comb begin
    // NOTE: every combinational output is assigned a default first so no path
    // through the block can leave it unassigned and infer a latch.
    rem_next = '0;
    quo_next = '0;
    shifted  = {rem_q, quo_q[XLEN-1]};
    trial    = shifted - {1'b0, divisor};
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      // A negative trial implies shifted < divisor, so its top bit is zero.
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction applied when the result is registered
  always_comb begin
    quo_final = quo_neg ? -quo_q : quo_q;
    rem_final = rem_neg ? -rem_q : rem_q;
  end

  // Control FSM and datapath registers; RESET beats FLUSH beats START
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RESET) begin
      state   <= S_IDLE;
      op_rem  <= 1'b0;
      quo_neg <= 1'b0;
      rem_neg <= 1'b0;
      divisor <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      count   <= '0;
      RESULT  <= '0;
      VALID   <= 1'b0;
    end else if (FLUSH) begin
      // Abort in CALC/FINISH, or drop a request arriving in IDLE.
      state <= S_IDLE;
      VALID <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START && op_valid) begin
            op_rem  <= op_is_rem;
            divisor <= divisor_abs;
            count   <= '0;
            if (div_by_zero) begin
              // Quotient all ones, remainder is the dividend, no sign fix-up.
              quo_q   <= '1;
              rem_q   <= DATA1;
              quo_neg <= 1'b0;
              rem_neg <= 1'b0;
              state   <= S_FINISH;
            end else if (overflow) begin
              quo_q   <= MOST_NEG;
              rem_q   <= '0;
              quo_neg <= 1'b0;
              rem_neg <= 1'b0;
              state   <= S_FINISH;
            end else begin
              quo_q   <= dividend_abs;
              rem_q   <= '0;
              quo_neg <= dividend_neg ^ divisor_neg;
              rem_neg <= dividend_neg;
              state   <= S_CALC;
            end
          end
        end

        S_CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          count <= count + CW'(1);
          if (count == LAST_COUNT) begin
            state <= S_FINISH;
          end
        end

        S_FINISH: begin
          RESULT <= op_rem ? rem_final : quo_final;
          VALID  <= 1'b1;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The pipeline stalls whenever an operation is in flight
  assign BUSY = (state != S_IDLE);

endmodule
